// File: rtl/uart_bus_bridge_if.sv
// Peripheral bus between the uart command bridge (master) and a 12-bit-addressed slave.
// A transfer is open while sel_o is high; the slave closes it with a single-cycle ack_i.
interface uart_bus_bridge_if;
   logic        sel_o;
   logic        wr_en_o;
   logic [11:0] address_o;
   logic [31:0] data_o;
   logic [31:0] data_in_i;
   logic        ack_i;

   modport master (
      output sel_o, wr_en_o, address_o, data_o,
      input  data_in_i, ack_i
   );

   modport slave (
      input  sel_o, wr_en_o, address_o, data_o,
      output data_in_i, ack_i
   );
endinterface

// File: rtl/uart_bus_bridge.sv
// Parses 'W'/'R' command bytes from a uart receiver, runs one bus transfer per command and
// returns 'K', the read word (LSB first) or 'E' on timeout through the uart transmitter.
// Handshake: rx_valid_i is a one-cycle strobe with no backpressure (bytes are taken only while
// parsing, otherwise dropped); tx_wr_o is a one-cycle strobe issued only in a cycle after
// tx_busy_i was seen low, and tx_data_o holds until the next strobe.
module uart_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    reset_i,
   input  logic                    rx_valid_i,
   input  logic [7:0]              rx_data_i,
   output logic                    tx_wr_o,
   output logic [7:0]              tx_data_o,
   input  logic                    tx_busy_i,
   uart_bus_bridge_if.master       bus,
   output logic                    busy_o,
   output logic                    error_o,
   output logic [2:0]              o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS, S_RESP, S_TX_WAIT
   } state_t;

   localparam logic [15:0] LP_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  LP_CMD_WRITE  = 8'h57;
   localparam logic [7:0]  LP_CMD_READ   = 8'h52;
   localparam logic [7:0]  LP_RESP_OK    = 8'h4B;
   localparam logic [7:0]  LP_RESP_ERR   = 8'h45;

   state_t      r_state;
   logic        r_is_write;
   logic        r_sel;
   logic        r_wr_en;
   logic [11:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_resp;
   logic [1:0]  r_resp_left;
   logic [1:0]  r_byte_cnt;
   logic [15:0] r_timer;
   logic        r_wait;
   logic        r_tx_wr;
   logic [7:0]  r_tx_data;
   logic        r_error;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_is_write  <= 1'b0;
         r_sel       <= 1'b0;
         r_wr_en     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_resp      <= '0;
         r_resp_left <= '0;
         r_byte_cnt  <= '0;
         r_timer     <= '0;
         r_wait      <= 1'b0;
         r_tx_wr     <= 1'b0;
         r_tx_data   <= '0;
         r_error     <= 1'b0;
      end else begin
         r_tx_wr <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rx_valid_i && (rx_data_i == LP_CMD_WRITE || rx_data_i == LP_CMD_READ)) begin
                  r_is_write <= (rx_data_i == LP_CMD_WRITE);
                  r_state    <= S_ADDR_HI;
               end
            end
            S_ADDR_HI: begin
               if (rx_valid_i) begin
                  r_addr[11:8] <= rx_data_i[3:0];
                  r_state      <= S_ADDR_LO;
               end
            end
            S_ADDR_LO: begin
               if (rx_valid_i) begin
                  r_addr[7:0] <= rx_data_i;
                  r_byte_cnt  <= '0;
                  if (r_is_write) begin
                     r_state <= S_DATA;
                  end else begin
                     r_sel   <= 1'b1;
                     r_wr_en <= 1'b0;
                     r_timer <= '0;
                     r_state <= S_BUS;
                  end
               end
            end
            S_DATA: begin
               if (rx_valid_i) begin
                  r_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data_i;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_sel   <= 1'b1;
                     r_wr_en <= 1'b1;
                     r_timer <= '0;
                     r_state <= S_BUS;
                  end
               end
            end
            S_BUS: begin
               // An ack on the last allowed cycle still wins over the timeout.
               if (bus.ack_i) begin
                  r_sel   <= 1'b0;
                  r_wr_en <= 1'b0;
                  r_state <= S_RESP;
                  if (r_is_write) begin
                     r_resp      <= {24'd0, LP_RESP_OK};
                     r_resp_left <= 2'd0;
                  end else begin
                     r_resp      <= bus.data_in_i;
                     r_resp_left <= 2'd3;
                  end
               end else if (r_timer == LP_TIMER_LAST) begin
                  r_sel       <= 1'b0;
                  r_wr_en     <= 1'b0;
                  r_error     <= 1'b1;
                  r_resp      <= {24'd0, LP_RESP_ERR};
                  r_resp_left <= 2'd0;
                  r_state     <= S_RESP;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            S_RESP: begin
               if (!tx_busy_i) begin
                  r_tx_wr   <= 1'b1;
                  r_tx_data <= r_resp[7:0];
                  r_resp    <= {8'd0, r_resp[31:8]};
                  r_wait    <= 1'b0;
                  r_state   <= S_TX_WAIT;
               end
            end
            S_TX_WAIT: begin
               // Two blind cycles give the transmitter time to raise tx_busy_i.
               if (!r_wait) begin
                  r_wait <= 1'b1;
               end else if (r_resp_left == 2'd0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_resp_left <= r_resp_left - 2'd1;
                  r_state     <= S_RESP;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sel_o     = r_sel;
   assign bus.wr_en_o   = r_wr_en;
   assign bus.address_o = r_addr;
   assign bus.data_o    = r_wdata;
   assign tx_wr_o       = r_tx_wr;
   assign tx_data_o     = r_tx_data;
   assign error_o       = r_error;
   assign busy_o        = (r_state != S_IDLE);
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized bench for uart_bus_bridge: a memory-backed slave, a uart transmitter model and a
// command-level reference model that predicts bus windows and response bytes.
module tb_uart_bus_bridge;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        tx_wr_o;
   logic [7:0]  tx_data_o;
   logic        tx_busy_i;
   logic        busy_o;
   logic        error_o;
   logic [2:0]  dbg_state;

   uart_bus_bridge_if bus ();

   uart_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .reset_i    (reset_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .tx_wr_o    (tx_wr_o),
      .tx_data_o  (tx_data_o),
      .tx_busy_i  (tx_busy_i),
      .bus        (bus),
      .busy_o     (busy_o),
      .error_o    (error_o),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_init(input int a);
      return {20'hC0DE5, a[11:0]};
   endfunction

   // ---------------- observation ----------------
   logic [7:0]  got_tx[$];
   logic [7:0]  exp_q[$];
   int          win_len_q[$];
   logic [11:0] win_addr_q[$];
   logic        win_wr_q[$];
   logic [31:0] win_data_q[$];
   int          err_pulses, busy_viol, win_bad;
   logic        prev_busy = 1'b0;
   logic        prev_sel  = 1'b0;
   int          cur_len;
   logic [11:0] cur_addr;
   logic        cur_wr;
   logic [31:0] cur_data;

   always @(negedge clk) begin
      if (tx_wr_o === 1'b1) begin
         got_tx.push_back(tx_data_o);
         if (prev_busy) busy_viol++;
      end
      if (error_o === 1'b1) err_pulses++;
      if (bus.sel_o === 1'b1) begin
         if (!prev_sel) begin
            cur_len  = 1;
            cur_addr = bus.address_o;
            cur_wr   = bus.wr_en_o;
            cur_data = bus.data_o;
         end else begin
            cur_len++;
            if (bus.address_o !== cur_addr || bus.wr_en_o !== cur_wr || bus.data_o !== cur_data)
               win_bad++;
         end
      end else if (prev_sel) begin
         win_len_q.push_back(cur_len);
         win_addr_q.push_back(cur_addr);
         win_wr_q.push_back(cur_wr);
         win_data_q.push_back(cur_data);
      end
      prev_sel  = (bus.sel_o === 1'b1);
      prev_busy = (tx_busy_i === 1'b1);
   end

   task automatic clear_obs();
      got_tx.delete();
      win_len_q.delete();
      win_addr_q.delete();
      win_wr_q.delete();
      win_data_q.delete();
      err_pulses = 0;
      busy_viol  = 0;
      win_bad    = 0;
   endtask

   // ---------------- uart transmitter model ----------------
   int busy_len = 3;
   int busy_cnt = 0;
   initial begin
      tx_busy_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (busy_cnt > 0) busy_cnt--;
         if (tx_wr_o === 1'b1) busy_cnt = busy_len;
         tx_busy_i = (busy_cnt > 0);
      end
   end

   // ---------------- bus slave ----------------
   int          ack_delay = 0;
   int          sel_cnt = 0;
   logic [31:0] slave_mem[int];
   logic [31:0] ref_mem[int];
   initial begin
      int a;
      bus.ack_i     = 1'b0;
      bus.data_in_i = '0;
      forever begin
         @(posedge clk); #1;
         bus.ack_i     = 1'b0;
         bus.data_in_i = $urandom;
         if (bus.sel_o === 1'b1) begin
            if (sel_cnt == ack_delay) begin
               bus.ack_i = 1'b1;
               a = int'(bus.address_o);
               if (bus.wr_en_o) slave_mem[a] = bus.data_o;
               else bus.data_in_i = slave_mem.exists(a) ? slave_mem[a] : mem_init(a);
            end
            sel_cnt++;
         end else begin
            sel_cnt = 0;
            // Stray acks outside a transfer must be ignored.
            if ($urandom_range(0, 3) == 0) bus.ack_i = 1'b1;
         end
      end
   end

   // ---------------- drivers ----------------
   logic [31:0] last_wd = '0;

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      @(posedge clk); #1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (busy_o && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(n >= 3000), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tx_wr"},   32'(tx_wr_o),       32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data_o),     32'd0);
      chk({tag, "_sel"},     32'(bus.sel_o),     32'd0);
      chk({tag, "_wr_en"},   32'(bus.wr_en_o),   32'd0);
      chk({tag, "_addr"},    32'(bus.address_o), 32'd0);
      chk({tag, "_data"},    bus.data_o,         32'd0);
      chk({tag, "_busy"},    32'(busy_o),        32'd0);
      chk({tag, "_error"},   32'(error_o),       32'd0);
   endtask

   task automatic run_cmd(input string tag, input bit is_wr, input logic [7:0] ahi,
                          input logic [7:0] alo, input logic [31:0] wd, input int delay,
                          input bit inject);
      int          a;
      bit          ok;
      logic [31:0] rv;
      logic [31:0] exp_data;
      clear_obs();
      ack_delay = delay;
      a  = int'({ahi[3:0], alo});
      ok = (delay < T);
      exp_q.delete();
      exp_data = is_wr ? wd : last_wd;
      if (!ok) begin
         exp_q.push_back(8'h45);
      end else if (is_wr) begin
         exp_q.push_back(8'h4B);
         ref_mem[a] = wd;
      end else begin
         rv = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
         for (int i = 0; i < 4; i++) exp_q.push_back(rv[8*i +: 8]);
      end
      if (is_wr) last_wd = wd;

      send_byte(is_wr ? 8'h57 : 8'h52);
      send_byte(ahi);
      send_byte(alo);
      if (is_wr) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
      if (inject) send_byte(8'h57);
      wait_idle(tag);

      chk({tag, "_win_count"}, 32'(win_len_q.size()), 32'd1);
      if (win_len_q.size() > 0) begin
         chk({tag, "_win_len"},  32'(win_len_q[0]), 32'(ok ? delay + 1 : T));
         chk({tag, "_win_addr"}, 32'(win_addr_q[0]), 32'(a));
         chk({tag, "_win_wr"},   32'(win_wr_q[0]), 32'(is_wr));
         chk({tag, "_win_data"}, win_data_q[0], exp_data);
      end
      chk({tag, "_sel_stable"}, 32'(win_bad), 32'd0);
      chk({tag, "_err_pulses"}, 32'(err_pulses), 32'(ok ? 0 : 1));
      chk({tag, "_tx_busy_ok"}, 32'(busy_viol), 32'd0);
      chk({tag, "_tx_count"}, 32'(got_tx.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_tx.size(); i++)
         chk({tag, "_tx_byte"}, 32'(got_tx[i]), 32'(exp_q[i]));
      chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
      chk({tag, "_addr_hold"}, 32'(bus.address_o), 32'(a));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          n;
      logic [7:0]  g;
      reset_i    = 1'b1;
      rx_valid_i = 1'b0;
      rx_data_i  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1 reset_i = 1'b0;

      busy_len = 3;
      run_cmd("write", 1'b1, 8'h0A, 8'hBC, 32'h12345678, 3, 1'b0);

      slave_mem[4] = 32'hDEADBEEF;
      ref_mem[4]   = 32'hDEADBEEF;
      busy_len = 100;
      run_cmd("read", 1'b0, 8'h00, 8'h04, 32'h0, 0, 1'b0);

      busy_len = 2;
      run_cmd("timeout", 1'b0, 8'h00, 8'h10, 32'h0, 1000, 1'b0);
      run_cmd("last_ack", 1'b0, 8'h00, 8'h10, 32'h0, T - 1, 1'b0);

      clear_obs();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h41);
      repeat (10) @(negedge clk);
      chk("garbage_tx", 32'(got_tx.size()), 32'd0);
      chk("garbage_win", 32'(win_len_q.size()), 32'd0);
      chk("garbage_busy", 32'(busy_o), 32'd0);
      run_cmd("inject", 1'b0, 8'h00, 8'h00, 32'h0, 6, 1'b1);

      clear_obs();
      send_byte(8'h57);
      send_byte(8'h01);
      @(posedge clk); #1 reset_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_parse");
      @(posedge clk); #1 reset_i = 1'b0;
      last_wd = '0;
      run_cmd("post_reset", 1'b0, 8'h00, 8'h00, 32'h0, 2, 1'b0);

      clear_obs();
      ack_delay = 1000;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h10);
      n = 0;
      while (bus.sel_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_bus_sel_seen", 32'(bus.sel_o), 32'd1);
      @(posedge clk); #1 reset_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("rst_bus");
      @(posedge clk); #1 reset_i = 1'b0;
      last_wd = '0;
      repeat (20) @(negedge clk);
      chk("rst_bus_no_tx", 32'(got_tx.size()), 32'd0);
      chk("rst_bus_no_err", 32'(err_pulses), 32'd0);

      busy_len = 1;
      run_cmd("mask", 1'b0, 8'hF1, 8'h23, 32'h0, 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         busy_len = $urandom_range(0, 5);
         if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom);
            if (g == 8'h57 || g == 8'h52) g = 8'h00;
            send_byte(g);
         end
         run_cmd("rand", 1'($urandom_range(0, 1)),
                 {4'($urandom), 4'($urandom_range(0, 1))}, 8'($urandom_range(0, 7)),
                 $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(T, T + 4)
                                                       : $urandom_range(0, T - 1), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end
endmodule
